// File: rtl/hpq_ctrl_pkg.sv
// Shared types and width/latency helpers for the multi-level PQ search controller.
package hpq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CENT,
    S_DRAIN,
    S_SCAN,
    S_CMPW,
    S_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Enabled cycles spent on one hierarchy level.
  function automatic int l1(input int nc, input int sqdl, input int vd, input int cmpl);
    return nc + sqdl + vd + cmpl;
  endfunction

endpackage

// File: rtl/ctrl_delayline.sv
// Enable-gated shift register that aligns centroid reads with distance writes.
module ctrl_delayline #(
  parameter int W = 2,
  parameter int L = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else if (ena) begin
      if (clr) begin
        for (int i = 0; i < L; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= din;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[L-1];

endmodule

// File: rtl/hpq_level_ctrl.sv
// Sequences LEVELS search levels: centroid reads, distance writes, Yt scan, comparator drain.
module hpq_level_ctrl
  import hpq_ctrl_pkg::*;
#(
  parameter int KT     = 32,
  parameter int PT     = 16,
  parameter int SQDL   = 5,
  parameter int VD     = 4,
  parameter int CMPL   = 11,
  parameter int LEVELS = 2,
  localparam int NC    = KT / PT,
  localparam int AW    = max1(clog2(NC)),
  localparam int OW    = max1(clog2(VD)),
  localparam int LW    = max1(clog2(LEVELS))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] level,
  output logic          cent_rd,
  output logic [AW-1:0] cent_addr,
  output logic          dist_wena,
  output logic [AW-1:0] dist_addr,
  output logic          scan_vld,
  output logic [OW-1:0] scan_offset,
  output logic          cmp_clr
);

  localparam int WMAX = (SQDL > CMPL) ? SQDL : CMPL;
  localparam int WW   = max1(clog2(WMAX));

  localparam logic [AW-1:0] CENT_LAST  = AW'(NC - 1);
  localparam logic [OW-1:0] SCAN_LAST  = OW'(VD - 1);
  localparam logic [WW-1:0] DRAIN_LAST = WW'(SQDL - 1);
  localparam logic [WW-1:0] CMPW_LAST  = WW'(CMPL - 1);
  localparam logic [LW-1:0] LEVEL_LAST = LW'(LEVELS - 1);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] cent_cnt;
  logic [OW-1:0] scan_cnt;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] level_q;

  logic cent_last;
  logic scan_last;
  logic drain_last;
  logic cmpw_last;

  logic cent_rd_raw;
  logic scan_raw;
  logic done_raw;
  logic clr_raw;
  logic dist_v;

  assign cent_last  = (cent_cnt == CENT_LAST);
  assign scan_last  = (scan_cnt == SCAN_LAST);
  assign drain_last = (wait_cnt == DRAIN_LAST);
  assign cmpw_last  = (wait_cnt == CMPW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else if (ena) state_q <= state_d;
  end

  // abort overrides every transition, including a start seen in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CENT;
      S_CENT:  if (cent_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_SCAN;
      S_SCAN:  if (scan_last) state_d = S_CMPW;
      S_CMPW:  if (cmpw_last) state_d = (level_q == LEVEL_LAST) ? S_DONE : S_CENT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    cent_rd_raw = 1'b0;
    scan_raw    = 1'b0;
    done_raw    = 1'b0;
    clr_raw     = 1'b0;
    case (state_q)
      S_CENT: begin
        cent_rd_raw = 1'b1;
        clr_raw     = (cent_cnt == '0);
      end
      S_SCAN:  scan_raw = 1'b1;
      S_DONE:  done_raw = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cent_cnt <= '0;
      scan_cnt <= '0;
      wait_cnt <= '0;
      level_q  <= '0;
    end else if (ena) begin
      if (abort) begin
        cent_cnt <= '0;
        scan_cnt <= '0;
        wait_cnt <= '0;
        level_q  <= '0;
      end else begin
        cent_cnt <= (state_q == S_CENT && !cent_last) ? cent_cnt + 1'b1 : '0;
        scan_cnt <= (state_q == S_SCAN && !scan_last) ? scan_cnt + 1'b1 : '0;
        if (state_q == S_DRAIN) wait_cnt <= drain_last ? '0 : wait_cnt + 1'b1;
        else if (state_q == S_CMPW) wait_cnt <= cmpw_last ? '0 : wait_cnt + 1'b1;
        else wait_cnt <= '0;
        if (state_q == S_CMPW && cmpw_last && level_q != LEVEL_LAST) level_q <= level_q + 1'b1;
        else if (state_q == S_DONE) level_q <= '0;
      end
    end
  end

  // Writes ride the delay line rather than a counter so stalls cannot misalign them.
  ctrl_delayline #(
    .W(1 + AW),
    .L(SQDL)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .clr (abort),
    .din ({cent_rd_raw, cent_cnt}),
    .dout({dist_v, dist_addr})
  );

  assign busy        = (state_q != S_IDLE);
  assign done        = done_raw & ena;
  assign level       = level_q;
  assign cent_rd     = cent_rd_raw & ena;
  assign cent_addr   = cent_cnt;
  assign dist_wena   = dist_v & ena;
  assign scan_vld    = scan_raw & ena;
  assign scan_offset = scan_cnt;
  assign cmp_clr     = clr_raw & ena;

endmodule

// File: tb/tb_hpq_level_ctrl.sv
// Directed plus random checking of two hpq_level_ctrl configurations against a schedule model.
module tb_hpq_level_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic       busy0, done0, cent_rd0, dist_wena0, scan_vld0, cmp_clr0;
  logic [0:0] level0, cent_addr0, dist_addr0;
  logic [1:0] scan_offset0;

  logic       busy1, done1, cent_rd1, dist_wena1, scan_vld1, cmp_clr1;
  logic [0:0] level1, cent_addr1, dist_addr1, scan_offset1;

  hpq_level_ctrl dut0 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .level(level0),
    .cent_rd(cent_rd0), .cent_addr(cent_addr0),
    .dist_wena(dist_wena0), .dist_addr(dist_addr0),
    .scan_vld(scan_vld0), .scan_offset(scan_offset0), .cmp_clr(cmp_clr0)
  );

  hpq_level_ctrl #(.KT(16), .PT(16), .SQDL(5), .VD(1), .CMPL(11), .LEVELS(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .level(level1),
    .cent_rd(cent_rd1), .cent_addr(cent_addr1),
    .dist_wena(dist_wena1), .dist_addr(dist_addr1),
    .scan_vld(scan_vld1), .scan_offset(scan_offset1), .cmp_clr(cmp_clr1)
  );

  typedef struct {
    int busy, done, level, cent_rd, cent_addr, dist_wena, dist_addr, scan_vld, scan_offset, cmp_clr;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pos0 = 0;
  int pos1 = 0;

  // pos = 0 when idle, else 1 + enabled edges since the start was accepted.
  function automatic exp_t model(input int nc, input int sqdl, input int vd, input int cmpl,
                                 input int lv, input int pos, input int en);
    exp_t m;
    int len, o;
    m = '{default: 0};
    len = nc + sqdl + vd + cmpl;
    if (pos == 0) return m;
    m.busy = 1;
    if (pos == lv * len + 1) begin
      m.done  = en;
      m.level = lv - 1;
      return m;
    end
    o = (pos - 1) % len;
    m.level = (pos - 1) / len;
    if (o < nc) begin
      m.cent_rd   = en;
      m.cent_addr = o;
    end
    m.cmp_clr = (o == 0) ? en : 0;
    if (o >= sqdl && o < sqdl + nc) begin
      m.dist_wena = en;
      m.dist_addr = o - sqdl;
    end
    if (o >= nc + sqdl && o < nc + sqdl + vd) begin
      m.scan_vld    = en;
      m.scan_offset = o - nc - sqdl;
    end
    return m;
  endfunction

  function automatic int next_pos(input int pos, input int tot, input logic r, input logic e,
                                  input logic s, input logic a);
    if (r) return 0;
    if (!e) return pos;
    if (a) return 0;
    if (pos == 0) return s ? 1 : 0;
    if (pos == tot + 1) return 0;
    return pos + 1;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t m0, m1;
    m0 = model(2, 5, 4, 11, 2, pos0, int'(ena));
    m1 = model(1, 5, 1, 11, 1, pos1, int'(ena));
    cmp("d0.busy", 32'(busy0), m0.busy);
    cmp("d0.done", 32'(done0), m0.done);
    cmp("d0.level", 32'(level0), m0.level);
    cmp("d0.cent_rd", 32'(cent_rd0), m0.cent_rd);
    cmp("d0.cent_addr", 32'(cent_addr0), m0.cent_addr);
    cmp("d0.dist_wena", 32'(dist_wena0), m0.dist_wena);
    cmp("d0.dist_addr", 32'(dist_addr0), m0.dist_addr);
    cmp("d0.scan_vld", 32'(scan_vld0), m0.scan_vld);
    cmp("d0.scan_offset", 32'(scan_offset0), m0.scan_offset);
    cmp("d0.cmp_clr", 32'(cmp_clr0), m0.cmp_clr);
    cmp("d1.busy", 32'(busy1), m1.busy);
    cmp("d1.done", 32'(done1), m1.done);
    cmp("d1.level", 32'(level1), m1.level);
    cmp("d1.cent_rd", 32'(cent_rd1), m1.cent_rd);
    cmp("d1.cent_addr", 32'(cent_addr1), m1.cent_addr);
    cmp("d1.dist_wena", 32'(dist_wena1), m1.dist_wena);
    cmp("d1.dist_addr", 32'(dist_addr1), m1.dist_addr);
    cmp("d1.scan_vld", 32'(scan_vld1), m1.scan_vld);
    cmp("d1.scan_offset", 32'(scan_offset1), m1.scan_offset);
    cmp("d1.cmp_clr", 32'(cmp_clr1), m1.cmp_clr);
  endtask

  // Called at a negedge: drive, check the cycle, advance the model at the posedge.
  task automatic step(input logic e, input logic s, input logic a);
    ena = e;
    start = s;
    abort = a;
    #1;
    check_all();
    @(posedge clk);
    pos0 = next_pos(pos0, 2 * 22, rst, e, s, a);
    pos1 = next_pos(pos1, 1 * 18, rst, e, s, a);
    cyc++;
    @(negedge clk);
  endtask

  task automatic async_reset();
    ena = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    pos0 = 0;
    pos1 = 0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;

    // Plain run: done at 45 (dut0) and 19 (dut1).
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 47; i++) step(1'b1, 1'b0, 1'b0);

    // Stalls: 3 cycles in CENT, 2 in DRAIN.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 44; i++) step(1'b1, 1'b0, 1'b0);

    // Abort in level-1 DRAIN, with an ignored stalled abort just before it.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 47; i++) step(1'b1, 1'b0, 1'b0);

    // start held high across runs.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 46; i++) step(1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-SCAN, then recovery.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 47; i++) step(1'b1, 1'b0, 1'b0);

    // Random traffic with stalls, starts and aborts.
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpq_level_ctrl.md
Name: hpq_level_ctrl

Overview:
- Multi-level successor to the single-pass search controller.
- Sequences LEVELS hierarchy levels back to back. Per level:
  - codebook centroid reads;
  - latency-matched distance writes;
  - database offset scan;
  - comparator drain.
- Provides a start/busy/done handshake, a global clock-enable stall and a synchronous abort. Sits between the host command interface and the codebook/distance/Yt RAM datapath.

Parameters:
- KT, 32, PQ codebook size.
- PT, 16, codebook-phase parallelism; NC = KT/PT centroid read cycles per level (KT multiple of PT, NC>=1).
- SQDL, 5, squared-distance unit latency in cycles (>=1).
- VD, 4, Voronoi-cell scan depth per level (>=1).
- CMPL, 11, comparator tree latency in cycles (>=1).
- LEVELS, 2, hierarchy levels per search (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  global clock-enable; 0 freezes all state
- start  in  1  search request; accepted only in IDLE with ena=1
- abort  in  1  synchronous cancel, any state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at search completion
- level  out  LW  current level index, LW=max(1,clog2(LEVELS))
- cent_rd  out  1  centroid RAM read strobe
- cent_addr  out  AW  centroid read address, AW=max(1,clog2(NC))
- dist_wena  out  1  distance RAM write enable
- dist_addr  out  AW  distance RAM write address
- scan_vld  out  1  Yt RAM read strobe
- scan_offset  out  OW  Yt offset, OW=max(1,clog2(VD))
- cmp_clr  out  1  one-cycle pulse clearing comparator min at level start

Behaviour:
- Reset:
  - state IDLE;
  - all counters, level and the delay line cleared;
  - every output 0.
- ena=0:
  - state, counters and delay line hold;
  - cent_rd, dist_wena, scan_vld, done and cmp_clr are ANDed with ena, so they are 0 while stalled;
  - addresses and level hold.
- States: IDLE, CENT, DRAIN, SCAN, CMPW, DONE. Cycle counts below are enabled cycles.
- IDLE: start=1 -> CENT. level=0, cent_addr=0, cmp_clr pulses in the first CENT cycle.
- CENT:
  - cent_rd=1, cent_addr counts 0..NC-1;
  - after the cycle with cent_addr=NC-1 -> DRAIN, cent_addr returns to 0.
- Distance path:
  - dist_wena and dist_addr equal cent_rd and cent_addr delayed exactly SQDL enabled cycles, through the delay line;
  - the writes are counter-free, so reads and writes stay aligned across stalls.
- DRAIN: lasts SQDL cycles, then -> SCAN. The last dist_wena occurs in the final DRAIN cycle.
- SCAN: scan_vld=1, scan_offset 0..VD-1, then -> CMPW with offset back to 0.
- CMPW: lasts CMPL cycles. Exit:
  - if level==LEVELS-1 -> DONE;
  - else level+1 -> CENT, with cmp_clr in the first CENT cycle.
- DONE: done=1 for one cycle -> IDLE. level resets to 0 on entry to IDLE.
- Latency:
  - per level L1 = NC+SQDL+VD+CMPL;
  - done is in cycle LEVELS*L1+1 after the start-accept edge.
- start while busy: ignored (no queueing).
- start in the DONE cycle: ignored.
- abort=1 with ena=1, from any state:
  - next state IDLE;
  - counters, level and delay line cleared;
  - pending dist_wena is squashed;
  - done is not asserted.
- abort and start in the same cycle: abort wins, stay IDLE.
- abort with ena=0: not acted on.
- rst mid-operation: immediate IDLE, all outputs 0 asynchronously for registered outputs.
- Counter rules: unsigned, wrap explicitly to 0 at their terminal value; never free-run past it.

Decomposition:
- Package hpq_ctrl_pkg holds:
  - the state enumeration;
  - width functions clog2 and max1 for AW/OW/LW;
  - derived-constant function L1.
- One sub-module, ctrl_delayline:
  - width W (here 1+AW), depth L=SQDL;
  - ena hold;
  - synchronous clear input used for abort;
  - async rst.

Test Plan:
- Defaults (NC=2, SQDL=5, VD=4, CMPL=11, LEVELS=2), start pulse -> cent_rd at cycles 1-2 addr 0,1; dist_wena at cycles 6-7 addr 0,1; scan_vld at 8-11 offsets 0..3; level=1 at cycle 23; done only at cycle 45; busy cycles 1-45.
- Same run with ena=0 for 3 cycles during CENT and 2 during DRAIN -> every strobe sequence identical, shifted by 5; done at cycle 50; no duplicated or dropped dist_wena.
- abort during level-1 DRAIN -> IDLE next cycle, no done, no further dist_wena; a new start then gives a full 45-cycle run.
- start held high through a whole run -> exactly one run until DONE; a second run is accepted only in the cycle after DONE (IDLE).
- LEVELS=1, KT=PT (NC=1), VD=1 -> single cent_rd at addr 0; done at cycle 1+5+1+11+1=19.
- rst asserted mid-SCAN -> all outputs 0 immediately, level=0; recovery to a normal run after release.
